// File: rtl/seq_controller_if.sv
// rtl/seq_controller_if.sv - sequencer control/status bundle between datapath and seq_controller
interface seq_controller_if;
    logic       start;
    logic [3:0] icode;
    logic       instr_valid;
    logic       imem_error;
    logic       dmem_error;
    logic [2:0] cf_out;
    logic [5:0] stage_en;
    logic [2:0] cf_in;
    logic [2:0] stat;
    logic       busy;

    modport master (
        output start, icode, instr_valid, imem_error, dmem_error, cf_out,
        input  stage_en, cf_in, stat, busy
    );

    modport slave (
        input  start, icode, instr_valid, imem_error, dmem_error, cf_out,
        output stage_en, cf_in, stat, busy
    );
endinterface

// File: rtl/seq_controller.sv
// rtl/seq_controller.sv - six-stage sequential CPU controller; SEQ_PERF_CNT_EN adds cycle/instr counters
module seq_controller (
    input  logic           clk,
    input  logic           rst,
    seq_controller_if.slave bus
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0]    cycle_cnt,
    output logic [31:0]    instr_cnt
`endif
);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;
    localparam logic [3:0] ICODE_HALT = 4'h0;
    localparam logic [3:0] ICODE_OPQ  = 4'h6;
    localparam logic [2:0] CF_RESET   = 3'b100;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXECUTE,
        MEMORY,
        WRITEBACK,
        PCUPDATE,
        HALTED
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] stat_q, stat_d;
    logic [2:0] cf_q, cf_d;
    logic [3:0] icode_q, icode_d;
    logic [5:0] stage_en;
    logic       busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            stat_q  <= STAT_AOK;
            cf_q    <= CF_RESET;
            icode_q <= 4'h0;
        end else begin
            state_q <= state_d;
            stat_q  <= stat_d;
            cf_q    <= cf_d;
            icode_q <= icode_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        stat_d   = stat_q;
        cf_d     = cf_q;
        icode_d  = icode_q;
        stage_en = 6'b000000;
        busy     = 1'b1;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (bus.start) state_d = FETCH;
            end
            FETCH: begin
                stage_en = 6'b000001;
                icode_d  = bus.icode;
                // Address fault outranks an illegal encoding, which outranks halt.
                if (bus.imem_error) begin
                    state_d = HALTED;
                    stat_d  = STAT_ADR;
                end else if (!bus.instr_valid) begin
                    state_d = HALTED;
                    stat_d  = STAT_INS;
                end else if (bus.icode == ICODE_HALT) begin
                    state_d = HALTED;
                    stat_d  = STAT_HLT;
                end else begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                stage_en = 6'b000010;
                state_d  = EXECUTE;
            end
            EXECUTE: begin
                stage_en = 6'b000100;
                state_d  = MEMORY;
                // Only OPq writes the flags; the latched icode keeps fetch glitches out.
                if (icode_q == ICODE_OPQ) cf_d = bus.cf_out;
            end
            MEMORY: begin
                stage_en = 6'b001000;
                if (bus.dmem_error) begin
                    state_d = HALTED;
                    stat_d  = STAT_ADR;
                end else begin
                    state_d = WRITEBACK;
                end
            end
            WRITEBACK: begin
                stage_en = 6'b010000;
                state_d  = PCUPDATE;
            end
            PCUPDATE: begin
                stage_en = 6'b100000;
                state_d  = FETCH;
            end
            HALTED: begin
                busy = 1'b0;
            end
            default: begin
                busy    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.stage_en = stage_en;
    assign bus.cf_in    = cf_q;
    assign bus.stat     = stat_q;
    assign bus.busy     = busy;

`ifdef SEQ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= 32'd0;
            instr_cnt <= 32'd0;
        end else begin
            if (busy) cycle_cnt <= cycle_cnt + 32'd1;
            if (state_q == PCUPDATE) instr_cnt <= instr_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_seq_controller.sv
// tb/tb_seq_controller.sv - scoreboard bench for seq_controller
module tb_seq_controller;

    logic clk = 1'b0;
    logic rst;
    seq_controller_if bus ();
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instr_cnt;
`endif

    seq_controller dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave)
`ifdef SEQ_PERF_CNT_EN
        ,
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [12:0] v;
        logic        perf;
        logic [31:0] cc;
        logic [31:0] ic;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic [2:0] m_cf;
    logic [2:0] m_stat;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            logic [12:0] act;
            e = q.pop_front();
            act = {bus.stage_en, bus.cf_in, bus.stat, bus.busy};
            total++;
            if (e.cyc < cyc) begin
                bad++;
                $display("FAIL %s: sample missed at cycle %0d (expected cycle %0d)", e.name, cyc, e.cyc);
            end else if (act !== e.v) begin
                bad++;
                $display("FAIL %s: got se=%b cf=%b stat=%0d busy=%b, expected se=%b cf=%b stat=%0d busy=%b",
                         e.name, act[12:7], act[6:4], act[3:1], act[0],
                         e.v[12:7], e.v[6:4], e.v[3:1], e.v[0]);
            end
`ifdef SEQ_PERF_CNT_EN
            if (e.perf) begin
                total++;
                if (cycle_cnt !== e.cc || instr_cnt !== e.ic) begin
                    bad++;
                    $display("FAIL %s_perf: got cycle_cnt=%0d instr_cnt=%0d, expected cycle_cnt=%0d instr_cnt=%0d",
                             e.name, cycle_cnt, instr_cnt, e.cc, e.ic);
                end
            end
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expp(input string n, input logic [5:0] se, input logic bz,
                        input logic perf, input int cc, input int ic);
        exp_t e;
        e.cyc  = cyc;
        e.v    = {se, m_cf, m_stat, bz};
        e.perf = perf;
        e.cc   = cc;
        e.ic   = ic;
        e.name = n;
        q.push_back(e);
    endtask

    task automatic expect_state(input string n, input logic [5:0] se, input logic bz);
        expp(n, se, bz, 1'b0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.imem_error = 1'b0;
        bus.dmem_error = 1'b0;
        bus.instr_valid = 1'b1;
        bus.icode = 4'h6;
        bus.cf_out = 3'b000;
        tick();
        m_cf = 3'b100;
        m_stat = 3'd1;
        expp("reset", 6'b0, 1'b0, 1'b1, 0, 0);
        rst = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        expect_state("start_fetch", 6'b000001, 1'b1);
    endtask

    // Entered with the DUT in FETCH; leaves it in FETCH of the next instruction.
    task automatic run_instr(input logic [3:0] ic, input logic [2:0] cfo);
        bus.icode = ic;
        bus.cf_out = cfo;
        bus.instr_valid = 1'b1;
        tick();
        expect_state("decode", 6'b000010, 1'b1);
        bus.icode = (ic == 4'h6) ? 4'h2 : 4'h6;
        tick();
        expect_state("execute", 6'b000100, 1'b1);
        tick();
        if (ic == 4'h6) m_cf = cfo;
        expect_state("memory", 6'b001000, 1'b1);
        tick();
        expect_state("writeback", 6'b010000, 1'b1);
        tick();
        expect_state("pcupdate", 6'b100000, 1'b1);
        tick();
        expect_state("next_fetch", 6'b000001, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.icode = 4'h0;
        bus.instr_valid = 1'b0;
        bus.imem_error = 1'b0;
        bus.dmem_error = 1'b0;
        bus.cf_out = 3'b000;
        m_cf = 3'b100;
        m_stat = 3'd1;

        // OPq loads flags
        do_reset();
        do_start();
        run_instr(4'h6, 3'b010);

        // rrmovq leaves flags, then halt; start ignored while halted
        do_reset();
        do_start();
        run_instr(4'h2, 3'b001);
        bus.icode = 4'h0;
        tick();
        m_stat = 3'd2;
        expect_state("halt_hlt", 6'b0, 1'b0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        expect_state("halt_start_ignored", 6'b0, 1'b0);
        tick();
        expect_state("halt_hold", 6'b0, 1'b0);

        // imem_error beats invalid instruction
        do_reset();
        do_start();
        bus.imem_error = 1'b1;
        bus.instr_valid = 1'b0;
        tick();
        m_stat = 3'd3;
        expect_state("halt_imem_adr", 6'b0, 1'b0);
        bus.imem_error = 1'b0;
        bus.instr_valid = 1'b1;

        // illegal instruction alone
        do_reset();
        do_start();
        bus.instr_valid = 1'b0;
        tick();
        m_stat = 3'd4;
        expect_state("halt_ins", 6'b0, 1'b0);
        bus.instr_valid = 1'b1;

        // dmem_error in MEMORY: no writeback
        do_reset();
        do_start();
        bus.icode = 4'h6;
        bus.cf_out = 3'b111;
        tick();
        expect_state("dm_decode", 6'b000010, 1'b1);
        tick();
        expect_state("dm_execute", 6'b000100, 1'b1);
        tick();
        m_cf = 3'b111;
        expect_state("dm_memory", 6'b001000, 1'b1);
        bus.dmem_error = 1'b1;
        tick();
        bus.dmem_error = 1'b0;
        m_stat = 3'd3;
        expect_state("halt_dmem_adr", 6'b0, 1'b0);
        tick();
        expect_state("dmem_no_wb", 6'b0, 1'b0);

        // reset during EXECUTE aborts the flag update
        do_reset();
        do_start();
        bus.icode = 4'h6;
        bus.cf_out = 3'b011;
        tick();
        expect_state("ab_decode", 6'b000010, 1'b1);
        tick();
        expect_state("ab_execute", 6'b000100, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_cf = 3'b100;
        m_stat = 3'd1;
        expp("rst_in_execute", 6'b0, 1'b0, 1'b1, 0, 0);
        tick();
        expect_state("abort_stays_idle", 6'b0, 1'b0);

        // three OPq then halt: 3*6 + final fetch busy cycles
        do_reset();
        do_start();
        run_instr(4'h6, 3'b001);
        run_instr(4'h6, 3'b110);
        run_instr(4'h6, 3'b000);
        bus.icode = 4'h0;
        tick();
        m_stat = 3'd2;
        expp("perf_halt", 6'b0, 1'b0, 1'b1, 19, 3);
        tick();
        expp("perf_hold", 6'b0, 1'b0, 1'b1, 19, 3);

        for (int i = 0; i < 20 && q.size() > 0; i++) tick();
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_controller.md
SEQ_CONTROLLER -- requirements
Module: seq_controller

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port start, input, 1, single-cycle pulse that begins execution from IDLE.
REQ-004 SHALL have port icode, input, 4, instruction code from fetch, sampled in FETCH.
REQ-005 SHALL have port instr_valid, input, 1, fetch decoded a legal icode/ifun, sampled in FETCH.
REQ-006 SHALL have port imem_error, input, 1, instruction address fault, sampled in FETCH.
REQ-007 SHALL have port dmem_error, input, 1, data address fault, sampled in MEMORY.
REQ-008 SHALL have port cf_out, input, 3, {ZF,SF,OF} produced by the execute stage.
REQ-009 SHALL have port stage_en, output, 6, one-hot {pc_update,writeback,memory,execute,decode,fetch}; all-zero when not in a stage state.
REQ-010 SHALL have port cf_in, output, 3, registered condition flags that drive the execute stage.
REQ-011 SHALL have port stat, output, 3, status: 1=AOK, 2=HLT, 3=ADR, 4=INS.
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE and HALTED.

Function
REQ-013 SHALL implement the states IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPDATE and HALTED; each stage state lasts exactly one cycle.
REQ-014 SHALL move IDLE->FETCH on the cycle after start=1; start SHALL be ignored in every other state.
REQ-015 SHALL in FETCH apply priority imem_error > !instr_valid > icode==0: go to HALTED with stat=ADR, INS or HLT respectively; otherwise go to DECODE.
REQ-016 SHALL sequence DECODE->EXECUTE->MEMORY->WRITEBACK->PCUPDATE->FETCH, 6 cycles per instruction, with no stage skipped.
REQ-017 SHALL in MEMORY go to HALTED with stat=ADR when dmem_error=1, so that WRITEBACK and PCUPDATE never assert for that instruction.
REQ-018 SHALL load cf_in from cf_out at the end of the EXECUTE cycle only when icode==4'h6 (OPq), using the icode latched in FETCH; otherwise cf_in SHALL hold.
REQ-019 SHALL latch icode in FETCH and hold it through PCUPDATE; later changes on the icode input SHALL have no effect.
REQ-020 SHALL keep HALTED until rst; stage_en=0, busy=0, and stat and cf_in held.
REQ-021 SHALL keep stat=AOK during normal execution; stat SHALL change only on a halting event.

Reset
REQ-022 SHALL on rst=1 at a clock edge enter IDLE, set stage_en=0, cf_in=3'b100 (ZF=1), stat=AOK, busy=0 and clear the latched icode, regardless of current state; rst has priority over start and over all errors.
REQ-023 SHALL treat rst during any stage as an abort: no further stage_en pulses and no cf_in update for the aborted instruction.

Configuration
REQ-024 SHALL, when SEQ_PERF_CNT_EN is defined, provide outputs cycle_cnt[31:0] (increments every cycle busy=1) and instr_cnt[31:0] (increments on each PCUPDATE exit); both cleared by rst, wrap modulo 2^32 and hold in HALTED.
REQ-025 SHALL, when SEQ_PERF_CNT_EN is undefined, omit cycle_cnt and instr_cnt ports and logic entirely, with all other behaviour identical.

Verification
REQ-026 Reset then start, with icode=6, instr_valid=1 and cf_out=3'b010 -> stage_en walks 000001..100000 over 6 cycles, cf_in=3'b010 after EXECUTE, stat=1.
REQ-027 icode=2 (rrmovq) with cf_out=3'b001 -> cf_in stays 3'b100 for the whole instruction.
REQ-028 icode=0 in FETCH -> next cycle HALTED, stat=2, busy=0, no DECODE pulse; a following start is ignored.
REQ-029 imem_error=1 and instr_valid=0 together in FETCH -> stat=3 (ADR wins); dmem_error=1 in MEMORY -> stat=3 and no WRITEBACK pulse.
REQ-030 rst asserted during EXECUTE -> next cycle IDLE, stage_en=0, cf_in=3'b100, and cycle_cnt=0 when SEQ_PERF_CNT_EN is defined.
REQ-031 With SEQ_PERF_CNT_EN defined, run 3 OPq instructions then halt -> instr_cnt=3 and cycle_cnt=19.
